// File: rtl/pgm_rom_fetch_ctrl.sv
// 68k BIOS/P-ROM fetch sequencer: one-line 64-bit read buffer, 4-phase req/ack to the DDRAM arbiter.
// Hits answer after HIT_WAIT+1 cycles; misses hold DTACK until ack falls. PGM_ROM_PREFETCH_EN adds a next-line buffer.
module pgm_rom_fetch_ctrl #(
  parameter int HIT_WAIT    = 1,
  parameter int TIMEOUT_CYC = 4095,
  parameter int SYNC_STAGES = 2
) (
  input  logic        fixed_20m_clk,
  input  logic        reset,
  input  logic        cpu_as_n,
  input  logic        cpu_rw_n,
  input  logic [22:0] cpu_adr,
  input  logic        rom_sel,
  input  logic        invalidate,
  output logic        cpu_dtack_n,
  output logic [15:0] cpu_din,
  output logic        mem_req,
  output logic [20:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  output logic        err
);

`ifdef PGM_ROM_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, HIT_CNT, REQ, RELEASE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [TW-1:0]          tcnt;
  logic [1:0]             hcnt;
  logic [22:0]            adr_q;
  logic                   data_ok;
  logic [63:0]            buf_dat, pf_dat;
  logic [20:0]            buf_tag, pf_tag;
  logic                   buf_vld, pf_vld;
  logic                   pf_pend;
  logic                   pf_act;

  logic        start, hit0, hit1, hit, fill, tmo, pf_go;
  logic        din_ok;
  logic [1:0]  din_sel;
  logic [63:0] din_line;

  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign start = (state == IDLE) && !cpu_as_n && rom_sel;
  assign hit0  = buf_vld && (buf_tag == cpu_adr[22:2]);
  assign hit1  = PF_EN && pf_vld && (pf_tag == cpu_adr[22:2]);
  assign hit   = hit0 || hit1;
  // Prefetch only when the bus is quiet; a CPU access waiting in IDLE always wins.
  assign pf_go = PF_EN && (state == IDLE) && !start && pf_pend && buf_vld;

  always_comb begin
    state_nxt = state;
    fill      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!cpu_rw_n)  state_nxt = DONE;
          else if (hit)   state_nxt = (HIT_WAIT == 0) ? DONE : HIT_CNT;
          else            state_nxt = REQ;
        end else if (pf_go) begin
          state_nxt = REQ;
        end
      end
      HIT_CNT: if (hcnt == 2'(HIT_WAIT - 1)) state_nxt = DONE;
      REQ: begin
        if (ack_s) begin
          fill      = 1'b1;
          state_nxt = RELEASE;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          tmo       = 1'b1;
          state_nxt = DRAIN;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          state_nxt = pf_act ? IDLE : DONE;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          tmo       = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN:   if (!ack_s) state_nxt = pf_act ? IDLE : DONE;
      DONE:    if (cpu_as_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-wait hit enters DONE straight from IDLE, before adr_q and data_ok are loaded.
  always_comb begin
    din_ok   = data_ok;
    din_sel  = adr_q[1:0];
    din_line = buf_dat;
    if (state == IDLE) begin
      din_ok   = cpu_rw_n;
      din_sel  = cpu_adr[1:0];
      din_line = hit0 ? buf_dat : pf_dat;
    end
  end

  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      state       <= IDLE;
      ack_sync    <= '0;
      tcnt        <= '0;
      hcnt        <= '0;
      adr_q       <= '0;
      data_ok     <= 1'b0;
      buf_dat     <= '0;
      buf_tag     <= '0;
      buf_vld     <= 1'b0;
      pf_dat      <= '0;
      pf_tag      <= '0;
      pf_vld      <= 1'b0;
      pf_pend     <= 1'b0;
      pf_act      <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      cpu_dtack_n <= 1'b1;
      cpu_din     <= 16'hFFFF;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      ack_sync[0] <= mem_ack;
      for (int i = 1; i < SYNC_STAGES; i++) ack_sync[i] <= ack_sync[i-1];

      if (state_nxt != state)                   tcnt <= '0;
      else if (state == REQ || state == RELEASE) tcnt <= tcnt + 1'b1;
      if (state_nxt != state)                   hcnt <= '0;
      else if (state == HIT_CNT)                hcnt <= hcnt + 1'b1;

      if (start) begin
        adr_q   <= cpu_adr;
        data_ok <= cpu_rw_n;
      end
      if (tmo) begin
        data_ok <= 1'b0;
        err     <= 1'b1;
      end

      // mem_addr is only loaded from IDLE, where mem_req is always low.
      if (state == IDLE && state_nxt == REQ) begin
        mem_addr <= start ? cpu_adr[22:2] : buf_tag + 21'd1;
        pf_act   <= !start;
      end
      mem_req <= (state_nxt == REQ);

      if (fill) begin
        if (pf_act) begin
          pf_dat <= mem_data;
          pf_tag <= mem_addr;
        end else begin
          buf_dat <= mem_data;
          buf_tag <= mem_addr;
        end
      end
      if (start && cpu_rw_n && !hit0 && hit1) begin
        buf_dat <= pf_dat;
        buf_tag <= pf_tag;
      end

      if (invalidate || tmo) begin
        buf_vld <= 1'b0;
        pf_vld  <= 1'b0;
      end else if (fill) begin
        if (pf_act) pf_vld  <= 1'b1;
        else        buf_vld <= 1'b1;
      end else if (start && cpu_rw_n && !hit0 && hit1) begin
        buf_vld <= 1'b1;
        pf_vld  <= 1'b0;
      end

      if (invalidate || start || pf_go) pf_pend <= 1'b0;
      else if (PF_EN && fill && !pf_act) pf_pend <= 1'b1;

      cpu_dtack_n <= !(state_nxt == DONE && !cpu_as_n);
      cpu_din     <= (state_nxt == DONE && din_ok) ? din_line[{din_sel, 4'b0000} +: 16] : 16'hFFFF;
    end
  end

endmodule

// File: tb/tb_pgm_rom_fetch_ctrl.sv
// Directed plus randomized bench for pgm_rom_fetch_ctrl with an abstract one-line cache model and a 4-phase arbiter model.
module tb_pgm_rom_fetch_ctrl;
  localparam int HIT_WAIT    = 1;
  localparam int TIMEOUT_CYC = 16;
  localparam int BOUND       = 200;

  logic        fixed_20m_clk = 1'b0;
  logic        reset         = 1'b1;
  logic        cpu_as_n      = 1'b1;
  logic        cpu_rw_n      = 1'b1;
  logic [22:0] cpu_adr       = '0;
  logic        rom_sel       = 1'b0;
  logic        invalidate    = 1'b0;
  logic        mem_ack       = 1'b0;
  logic [63:0] mem_data      = '0;
  logic        cpu_dtack_n;
  logic [15:0] cpu_din;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #25 fixed_20m_clk = ~fixed_20m_clk;

  pgm_rom_fetch_ctrl #(
    .HIT_WAIT(HIT_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(2)
  ) dut (
    .fixed_20m_clk(fixed_20m_clk), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_rw_n(cpu_rw_n),
    .cpu_adr(cpu_adr), .rom_sel(rom_sel), .invalidate(invalidate), .cpu_dtack_n(cpu_dtack_n),
    .cpu_din(cpu_din), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .err(err)
  );

  // Backing ROM contents per line address.
  function automatic logic [63:0] line_data(input logic [20:0] a);
    if (a == 21'd0) return 64'h4444_3333_2222_1111;
    return {a[15:0] ^ 16'hC3C3, a[15:0] ^ 16'h8181, a[15:0] ^ 16'h2424, a[15:0] ^ 16'h0F0F};
  endfunction

  // Arbiter: ack after a delay, hold until req drops, then release.
  bit ack_en  = 1'b1;
  bit rnd_dly = 1'b0;
  int ack_dly = 5;
  int rel_dly = 1;
  initial begin
    int d;
    forever begin
      @(posedge fixed_20m_clk);
      if (mem_req === 1'b1 && ack_en) begin
        d = rnd_dly ? int'($urandom_range(0, 6)) : ack_dly;
        repeat (d) @(posedge fixed_20m_clk);
        #1;
        mem_data = line_data(mem_addr);
        mem_ack  = 1'b1;
        while (mem_req === 1'b1) @(posedge fixed_20m_clk);
        d = rnd_dly ? int'($urandom_range(0, 4)) : rel_dly;
        repeat (d) @(posedge fixed_20m_clk);
        #1 mem_ack = 1'b0;
      end
    end
  end

  int          req_rises  = 0;
  int          req_hi     = 0;
  int          addr_moves = 0;
  logic        req_q      = 1'b0;
  logic [20:0] addr_q     = '0;
  logic [20:0] req_addr   = '0;
  always @(negedge fixed_20m_clk) begin
    if (mem_req === 1'b1 && req_q !== 1'b1) begin
      req_rises <= req_rises + 1;
      req_addr  <= mem_addr;
    end
    if (mem_req === 1'b1 && req_q === 1'b1 && mem_addr !== addr_q) addr_moves <= addr_moves + 1;
    if (mem_req === 1'b1) req_hi <= req_hi + 1;
    req_q  <= mem_req;
    addr_q <= mem_addr;
  end

  // Reference model: which line the buffer holds, if any.
  bit          m_vld = 1'b0;
  logic [20:0] m_tag = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_cycle(input logic [22:0] a, input logic rw, output int lat,
                           output logic [15:0] din, output logic ack_seen);
    @(posedge fixed_20m_clk); #1;
    cpu_adr  = a;
    cpu_rw_n = rw;
    rom_sel  = 1'b1;
    cpu_as_n = 1'b0;
    lat = 0;
    while (lat < BOUND) begin
      @(posedge fixed_20m_clk); #1;
      lat++;
      if (cpu_dtack_n === 1'b0) break;
    end
    din      = cpu_din;
    ack_seen = mem_ack;
    cpu_as_n = 1'b1;
    rom_sel  = 1'b0;
    @(posedge fixed_20m_clk); #1;
    chk("dtack_negate", 64'(cpu_dtack_n), 64'(1'b1));
  endtask

  task automatic do_read(input logic [22:0] a, input string tag);
    int          r0, lat;
    bit          exp_hit;
    logic [15:0] din;
    logic        ackv;
    logic [63:0] sh;
    r0      = req_rises;
    exp_hit = m_vld && (m_tag == a[22:2]);
    sh      = line_data(a[22:2]) >> (16 * int'(a[1:0]));
    cpu_cycle(a, 1'b1, lat, din, ackv);
    chk({tag, "_dtack_bound"}, 64'(lat < BOUND), 64'(1'b1));
    chk({tag, "_din"}, 64'(din), 64'(sh[15:0]));
    chk({tag, "_req_count"}, 64'(req_rises - r0), exp_hit ? 64'd0 : 64'd1);
    if (exp_hit) begin
      chk({tag, "_hit_lat"}, 64'(lat), 64'(HIT_WAIT + 1));
    end else begin
      chk({tag, "_req_addr"}, 64'(req_addr), 64'(a[22:2]));
      chk({tag, "_ack_low_at_dtack"}, 64'(ackv), 64'(1'b0));
      m_vld = 1'b1;
      m_tag = a[22:2];
    end
  endtask

  task automatic do_write(input logic [22:0] a, input string tag);
    int          r0, lat;
    logic [15:0] din;
    logic        ackv;
    r0 = req_rises;
    cpu_cycle(a, 1'b0, lat, din, ackv);
    chk({tag, "_lat"}, 64'(lat), 64'd1);
    chk({tag, "_din"}, 64'(din), 64'hFFFF);
    chk({tag, "_no_req"}, 64'(req_rises - r0), 64'd0);
  endtask

  task automatic pulse_inv();
    @(posedge fixed_20m_clk); #1 invalidate = 1'b1;
    @(posedge fixed_20m_clk); #1 invalidate = 1'b0;
    m_vld = 1'b0;
  endtask

  logic [20:0] tags [4] = '{21'h000000, 21'h020001, 21'h020002, 21'h1FFFFF};

  initial begin
    int          lat, r0, h0, cnt;
    logic [15:0] din;
    logic        ackv;
    int          op;

    repeat (3) @(posedge fixed_20m_clk);
    #1;
    chk("rst_dtack", 64'(cpu_dtack_n), 64'(1'b1));
    chk("rst_din",   64'(cpu_din),     64'hFFFF);
    chk("rst_req",   64'(mem_req),     64'(1'b0));
    chk("rst_addr",  64'(mem_addr),    64'd0);
    chk("rst_err",   64'(err),         64'(1'b0));
    reset = 1'b0;
    repeat (2) @(posedge fixed_20m_clk);

    do_read(23'h000000, "rd_000000");
    do_read(23'h000003, "rd_000006");
    do_read(23'h080004, "rd_100008_a");
    pulse_inv();
    do_read(23'h080004, "rd_100008_b");
    chk("inv_refetch_addr", 64'(req_addr), 64'h020001);
    do_write(23'h000008, "wr_000010");
    do_read(23'h080005, "rd_after_wr");

    rnd_dly = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0)      pulse_inv();
      else if (op == 1) do_write(23'($urandom), "rnd_wr");
      else              do_read({tags[$urandom_range(0, 3)], 2'($urandom_range(0, 3))}, "rnd_rd");
    end
    rnd_dly = 1'b0;
    chk("err_clear_before_timeout", 64'(err), 64'(1'b0));

    ack_en = 1'b0;
    h0 = req_hi;
    cpu_cycle(23'h000123, 1'b1, lat, din, ackv);
    chk("tmo_dtack_bound", 64'(lat < BOUND), 64'(1'b1));
    chk("tmo_req_cycles", 64'(req_hi - h0), 64'(TIMEOUT_CYC));
    chk("tmo_din", 64'(din), 64'hFFFF);
    chk("tmo_err", 64'(err), 64'(1'b1));
    m_vld  = 1'b0;
    ack_en = 1'b1;
    do_read(23'h080004, "rd_after_tmo");
    chk("err_sticky", 64'(err), 64'(1'b1));

    // Reset while the FSM sits in RELEASE (req already dropped, ack still high).
    pulse_inv();
    ack_dly = 2;
    rel_dly = 6;
    @(posedge fixed_20m_clk); #1;
    cpu_adr = 23'h000001; cpu_rw_n = 1'b1; rom_sel = 1'b1; cpu_as_n = 1'b0;
    cnt = 0;
    while (mem_req !== 1'b1 && cnt < BOUND) begin @(posedge fixed_20m_clk); #1; cnt++; end
    while (mem_req !== 1'b0 && cnt < BOUND) begin @(posedge fixed_20m_clk); #1; cnt++; end
    chk("release_reached", 64'(cnt < BOUND), 64'(1'b1));
    reset = 1'b1; cpu_as_n = 1'b1; rom_sel = 1'b0;
    @(posedge fixed_20m_clk); #1;
    chk("rst_mid_req",   64'(mem_req),     64'(1'b0));
    chk("rst_mid_dtack", 64'(cpu_dtack_n), 64'(1'b1));
    chk("rst_mid_err",   64'(err),         64'(1'b0));
    reset = 1'b0;
    m_vld = 1'b0;
    repeat (15) @(posedge fixed_20m_clk);
    r0 = req_rises;
    do_read(23'h000003, "rd_after_rst");
    chk("rst_then_miss", 64'(req_rises - r0), 64'd1);

    chk("addr_stable_under_req", 64'(addr_moves), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
